decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, pipelined successor to the single-register instruction decoder. Sits between the fetch stage and the register-file/execute stage.
- Accepts raw instructions over a valid/ready handshake and splits them into fields. Adds immediate extension, opcode-class decode, illegal-opcode detection and RAW-hazard tagging.
- A 2-entry skid buffer gives full throughput under back-pressure. Supports a synchronous flush.

Parameters:
- IW, 16: instruction width.
- OPW, 4: opcode width; field is in_instr[IW-1 -: OPW].
- RW, 3: register address width; rD, then flag (1 bit), then rA, then rB, packed MSB-down below the opcode.
- IMMW, 8: immediate width; field is in_instr[IMMW-1:0].
- DW, 16: width of the extended immediate; DW >= IMMW.
- IMM_OPS, 16'h0000: bitmask indexed by opcode; 1 = opcode uses the immediate instead of rB.
- WRITE_OPS, 16'hFFFF: bitmask indexed by opcode; 1 = opcode writes rD.
- ILLEGAL_OPS, 16'h0000: bitmask indexed by opcode; 1 = opcode is illegal.
- CNTW, 16: width of the decoded-instruction counter.

Ports:
- clock in 1: rising-edge clock.
- reset in 1: synchronous, active-low.
- flush in 1: synchronous pipeline flush.
- in_valid in 1: upstream instruction valid.
- in_ready out 1: stage can accept.
- in_instr in IW: raw instruction.
- out_valid out 1: decoded entry valid.
- out_ready in 1: downstream accepts.
- out_opcode out OPW: opcode field.
- out_rd out RW: destination address.
- out_flag out 1: flag bit.
- out_ra out RW: source A address.
- out_rb out RW: source B address.
- out_imm out IMMW: raw immediate.
- out_imm_ext out DW: extended immediate.
- out_uses_imm out 1: IMM_OPS[opcode].
- out_writes out 1: WRITE_OPS[opcode].
- out_illegal out 1: ILLEGAL_OPS[opcode].
- out_raw_hazard out 1: source depends on the previous instruction's rD.
- dec_count out CNTW: number of output transfers.

Behaviour:
- Reset (reset==0 at a clock edge):
  - out_valid=0, in_ready=1.
  - All out_* data fields = 0.
  - dec_count=0.
  - Hazard tracker cleared: last_rd=0, last_wr=0.
  - Reset has priority over flush and over any handshake, including mid-transfer.
- Transfers:
  - Input transfer = in_valid & in_ready at a clock edge.
  - Output transfer = out_valid & out_ready at a clock edge.
- Storage is two entries: main (drives out_*) and skid.
  - in_ready is registered: in_ready = !skid_valid.
- Latency: 1 cycle. An instruction accepted at edge N is visible on out_* with out_valid=1 after edge N, provided main was empty or draining.
- Cycle-level update rules:
  - Main empty, or main transferring out: main loads the skid entry if skid is valid, else the incoming instruction.
  - Main loaded from skid while an input transfer also occurs: skid takes the new instruction.
  - Main full and not transferring out, with an input transfer: skid captures the instruction; in_ready drops next cycle.
  - out_* remain stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; no drop, no duplication.
- Decode (combinational on the incoming instruction, registered into the entry):
  - out_imm_ext: sign-extended from IMMW to DW when flag=1, zero-extended when flag=0.
- RAW hazard, evaluated in program order at input acceptance:
  - hazard = last_wr & ((ra==last_rd) | (!uses_imm & rb==last_rd)).
  - Then last_rd <= rd and last_wr <= writes.
  - The tag travels with the entry.
  - An illegal instruction still updates the tracker.
- dec_count: +1 on every output transfer; wraps modulo 2^CNTW.
- Flush (flush==1, reset==1):
  - Next cycle: main and skid invalid, out_valid=0, in_ready=1, hazard tracker cleared.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts in dec_count.
  - Data fields hold their old values (don't-care while out_valid=0).
- Back-to-back: with out_ready held at 1, sustained throughput is 1 instruction/cycle.
- Simultaneous accept and drain with both entries full cannot occur, because in_ready=0.

Decomposition:
- Package decode_pkg:
  - Default widths and field offset constants: OP_LSB, RD_LSB, FLAG_BIT, RA_LSB, RB_LSB.
  - A packed struct decoded_t holding opcode, rd, flag, ra, rb, imm, imm_ext, uses_imm, writes, illegal, raw_hazard.
- Sub-module field_extract: purely combinational instruction -> decoded_t, excluding the hazard bit. Instantiated once.
- Skid buffer, hazard tracker and counter live in decode_stage.

Test Plan:
- Reset, then in_instr=16'h3A5C, in_valid=1, out_ready=1 (defaults) -> one cycle later:
  - out_opcode=3, out_rd=5, out_flag=0, out_ra=2, out_rb=7, out_imm=8'h5C, out_imm_ext=16'h005C.
  - dec_count=1 after the transfer.
- IMM_OPS bit 1 set; instr 16'h13F0 (flag=1, imm 8'hF0) -> out_imm_ext=16'hFFF0, out_uses_imm=1.
- Hazard pair, WRITE_OPS=16'hFFFF:
  - 16'h1200 (rd=1) then 16'h2020 (ra=1) -> second entry out_raw_hazard=1; first entry 0.
  - Same pair with a flush between them -> 0.
- Back-pressure:
  - out_ready=0; stream 3 instructions with in_valid=1 -> 2 accepted, in_ready=0 from the 3rd cycle, out_* stable.
  - Release out_ready -> all 3 emerge in order, with no bubble after the first.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed instructions never appear; dec_count unchanged.
- Reset asserted mid-stream while out_valid=1 -> all outputs 0 and in_ready=1 the next cycle. Count wrap with CNTW=2: 5 transfers -> dec_count=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared widths, field offsets and the decoded-entry record for the decode stage.
package decode_pkg;

    // Default field widths; the decoded_t record is built from these.
    localparam int IW_DEF   = 16;
    localparam int OPW_DEF  = 4;
    localparam int RW_DEF   = 3;
    localparam int IMMW_DEF = 8;
    localparam int DW_DEF   = 16;
    localparam int CNTW_DEF = 16;

    // Field positions, packed MSB-down: opcode, rd, flag, ra, rb; imm sits in the low bits.
    localparam int OP_LSB   = IW_DEF - OPW_DEF;
    localparam int RD_LSB   = OP_LSB - RW_DEF;
    localparam int FLAG_BIT = RD_LSB - 1;
    localparam int RA_LSB   = FLAG_BIT - RW_DEF;
    localparam int RB_LSB   = RA_LSB - RW_DEF;

    typedef struct packed {
        logic [OPW_DEF-1:0]  opcode;
        logic [RW_DEF-1:0]   rd;
        logic                flag;
        logic [RW_DEF-1:0]   ra;
        logic [RW_DEF-1:0]   rb;
        logic [IMMW_DEF-1:0] imm;
        logic [DW_DEF-1:0]   imm_ext;
        logic                uses_imm;
        logic                writes;
        logic                illegal;
        logic                raw_hazard;
    } decoded_t;

    // Sign- or zero-extend the immediate depending on the flag bit.
    function automatic logic [DW_DEF-1:0] extend_imm(input logic [IMMW_DEF-1:0] imm,
                                                      input logic                flag);
        logic [DW_DEF-1:0] ext;
        ext = flag ? {DW_DEF{imm[IMMW_DEF-1]}} : '0;
        ext[IMMW_DEF-1:0] = imm;
        return ext;
    endfunction

endpackage

// File: rtl/decode_stage_field_extract.sv
// Purely combinational split of a raw instruction into a decoded_t record.
// The hazard bit is left at zero; the stage fills it in at acceptance.
module field_extract
    import decode_pkg::*;
#(
    parameter logic [(2**OPW_DEF)-1:0] IMM_OPS     = 16'h0000,
    parameter logic [(2**OPW_DEF)-1:0] WRITE_OPS   = 16'hFFFF,
    parameter logic [(2**OPW_DEF)-1:0] ILLEGAL_OPS = 16'h0000
) (
    input  logic [IW_DEF-1:0] instr,
    output decoded_t          dec
);

    // Slice fields and look up the per-opcode class bits.
    always_comb begin
        dec            = '0;
        dec.opcode     = instr[OP_LSB +: OPW_DEF];
        dec.rd         = instr[RD_LSB +: RW_DEF];
        dec.flag       = instr[FLAG_BIT];
        dec.ra         = instr[RA_LSB +: RW_DEF];
        dec.rb         = instr[RB_LSB +: RW_DEF];
        dec.imm        = instr[IMMW_DEF-1:0];
        dec.imm_ext    = extend_imm(instr[IMMW_DEF-1:0], instr[FLAG_BIT]);
        dec.uses_imm   = IMM_OPS[instr[OP_LSB +: OPW_DEF]];
        dec.writes     = WRITE_OPS[instr[OP_LSB +: OPW_DEF]];
        dec.illegal    = ILLEGAL_OPS[instr[OP_LSB +: OPW_DEF]];
        dec.raw_hazard = 1'b0;
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined instruction decode stage: valid/ready input, 2-entry skid buffer,
// RAW-hazard tagging against the previously accepted instruction, and a
// counter of output transfers. Field widths come from decode_pkg; the width
// parameters here size the ports and are expected to match the package.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is !skid_valid (a flop), so it never depends on out_ready
// combinationally; out_* are held stable while out_valid=1 and out_ready=0.
module decode_stage
    import decode_pkg::*;
#(
    parameter int IW   = IW_DEF,
    parameter int OPW  = OPW_DEF,
    parameter int RW   = RW_DEF,
    parameter int IMMW = IMMW_DEF,
    parameter int DW   = DW_DEF,
    parameter logic [(2**OPW_DEF)-1:0] IMM_OPS     = 16'h0000,
    parameter logic [(2**OPW_DEF)-1:0] WRITE_OPS   = 16'hFFFF,
    parameter logic [(2**OPW_DEF)-1:0] ILLEGAL_OPS = 16'h0000,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_opcode,
    output logic [RW-1:0]   out_rd,
    output logic            out_flag,
    output logic [RW-1:0]   out_ra,
    output logic [RW-1:0]   out_rb,
    output logic [IMMW-1:0] out_imm,
    output logic [DW-1:0]   out_imm_ext,
    output logic            out_uses_imm,
    output logic            out_writes,
    output logic            out_illegal,
    output logic            out_raw_hazard,
    output logic [CNTW-1:0] dec_count
);

    decoded_t        new_dec;
    decoded_t        new_entry;
    decoded_t        main_q, main_d;
    decoded_t        skid_q, skid_d;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [RW-1:0]   last_rd_q, last_rd_d;
    logic            last_wr_q, last_wr_d;
    logic [CNTW-1:0] dec_count_q, dec_count_d;
    logic            in_xfer;
    logic            out_xfer;

    field_extract #(
        .IMM_OPS     (IMM_OPS),
        .WRITE_OPS   (WRITE_OPS),
        .ILLEGAL_OPS (ILLEGAL_OPS)
    ) u_field_extract (
        .instr (in_instr),
        .dec   (new_dec)
    );

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid_q & out_ready;

    // Tag the incoming instruction against the last accepted writer.
    always_comb begin
        new_entry            = new_dec;
        new_entry.raw_hazard = last_wr_q &
                               ((new_dec.ra == last_rd_q) |
                                (!new_dec.uses_imm & (new_dec.rb == last_rd_q)));
    end

    // Next-state for the two entries, the hazard tracker and the counter.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        last_rd_d    = last_rd_q;
        last_wr_d    = last_wr_q;
        dec_count_d  = dec_count_q + {{(CNTW-1){1'b0}}, out_xfer};

        if (flush) begin
            // Drop both entries and any instruction arriving this cycle;
            // data fields keep their old values.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            last_rd_d    = '0;
            last_wr_d    = 1'b0;
        end else begin
            if (in_xfer) begin
                last_rd_d = new_dec.rd;
                last_wr_d = new_dec.writes;
            end

            if (!main_valid_q || out_xfer) begin
                // Main is free this cycle: the older skid entry goes first.
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    if (in_xfer) begin
                        skid_d       = new_entry;
                        skid_valid_d = 1'b1;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else if (in_xfer) begin
                    main_d       = new_entry;
                    main_valid_d = 1'b1;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                // Main is stalled: park the new instruction in the skid slot.
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset wins over flush and any handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            last_rd_q    <= '0;
            last_wr_q    <= 1'b0;
            dec_count_q  <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            last_rd_q    <= last_rd_d;
            last_wr_q    <= last_wr_d;
            dec_count_q  <= dec_count_d;
        end
    end

    assign in_ready       = !skid_valid_q;
    assign out_valid      = main_valid_q;
    assign out_opcode     = main_q.opcode;
    assign out_rd         = main_q.rd;
    assign out_flag       = main_q.flag;
    assign out_ra         = main_q.ra;
    assign out_rb         = main_q.rb;
    assign out_imm        = main_q.imm;
    assign out_imm_ext    = main_q.imm_ext;
    assign out_uses_imm   = main_q.uses_imm;
    assign out_writes     = main_q.writes;
    assign out_illegal    = main_q.illegal;
    assign out_raw_hazard = main_q.raw_hazard;
    assign dec_count      = dec_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, immediate extension, hazard
// tagging, back-pressure, flush, reset and counter wrap.
module tb_decode_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid, out_flag, out_uses_imm, out_writes, out_illegal, out_raw_hazard;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd, out_ra, out_rb;
    logic [7:0]  out_imm;
    logic [15:0] out_imm_ext;
    logic [15:0] dec_count;

    logic        w_in_ready, w_out_valid, w_out_flag, w_out_uses_imm, w_out_writes, w_out_illegal, w_out_raw_hazard;
    logic [3:0]  w_out_opcode;
    logic [2:0]  w_out_rd, w_out_ra, w_out_rb;
    logic [7:0]  w_out_imm;
    logic [15:0] w_out_imm_ext;
    logic [1:0]  w_dec_count;

    int tests = 0;
    int fails = 0;

    decode_stage #(
        .IMM_OPS     (16'h0002),
        .WRITE_OPS   (16'hFFFF),
        .ILLEGAL_OPS (16'h8000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_rd         (out_rd),
        .out_flag       (out_flag),
        .out_ra         (out_ra),
        .out_rb         (out_rb),
        .out_imm        (out_imm),
        .out_imm_ext    (out_imm_ext),
        .out_uses_imm   (out_uses_imm),
        .out_writes     (out_writes),
        .out_illegal    (out_illegal),
        .out_raw_hazard (out_raw_hazard),
        .dec_count      (dec_count)
    );

    // Narrow-counter copy driven by the same stimulus, used for the wrap check.
    decode_stage #(
        .IMM_OPS     (16'h0002),
        .WRITE_OPS   (16'hFFFF),
        .ILLEGAL_OPS (16'h8000),
        .CNTW        (2)
    ) dut_w (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (w_in_ready),
        .in_instr       (in_instr),
        .out_valid      (w_out_valid),
        .out_ready      (out_ready),
        .out_opcode     (w_out_opcode),
        .out_rd         (w_out_rd),
        .out_flag       (w_out_flag),
        .out_ra         (w_out_ra),
        .out_rb         (w_out_rb),
        .out_imm        (w_out_imm),
        .out_imm_ext    (w_out_imm_ext),
        .out_uses_imm   (w_out_uses_imm),
        .out_writes     (w_out_writes),
        .out_illegal    (w_out_illegal),
        .out_raw_hazard (w_out_raw_hazard),
        .dec_count      (w_dec_count)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", dec_count, 0);
        check("rst_opcode", out_opcode, 0);
        check("rst_imm_ext", out_imm_ext, 0);
        check("rst_w_count", w_dec_count, 0);

        // Basic decode of 16'h3A5C
        reset    = 1'b1;
        in_instr = 16'h3A5C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("d1_valid", out_valid, 1);
        check("d1_opcode", out_opcode, 3);
        check("d1_rd", out_rd, 5);
        check("d1_flag", out_flag, 0);
        check("d1_ra", out_ra, 2);
        check("d1_rb", out_rb, 7);
        check("d1_imm", out_imm, 8'h5C);
        check("d1_imm_ext", out_imm_ext, 16'h005C);
        check("d1_uses_imm", out_uses_imm, 0);
        check("d1_writes", out_writes, 1);
        check("d1_hazard", out_raw_hazard, 0);
        check("d1_count_before", dec_count, 0);
        tick();
        check("d1_drained", out_valid, 0);
        check("d1_count", dec_count, 1);

        // Sign-extended immediate on an immediate opcode
        in_instr = 16'h13F0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("d2_imm_ext", out_imm_ext, 16'hFFF0);
        check("d2_uses_imm", out_uses_imm, 1);
        check("d2_flag", out_flag, 1);
        check("d2_hazard", out_raw_hazard, 0);
        tick();
        check("d2_count", dec_count, 2);

        // Hazard pair back-to-back
        in_instr = 16'h1200;
        in_valid = 1'b1;
        tick();
        check("hz_first", out_raw_hazard, 0);
        in_instr = 16'h2020;
        tick();
        in_valid = 1'b0;
        check("hz_second_opcode", out_opcode, 2);
        check("hz_second", out_raw_hazard, 1);
        check("hz_count", dec_count, 3);
        tick();

        // Same pair with a flush between them; last_rd is 0 here so 1200 (ra=0) hazards
        in_instr = 16'h1200;
        in_valid = 1'b1;
        tick();
        check("fz_first", out_raw_hazard, 1);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("fz_flushed_valid", out_valid, 0);
        check("fz_count", dec_count, 5);
        in_instr = 16'h2020;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fz_second", out_raw_hazard, 0);
        tick();
        check("fz_count_after", dec_count, 6);

        // Illegal opcode still updates the tracker
        in_instr = 16'hF200;
        in_valid = 1'b1;
        tick();
        check("il_illegal", out_illegal, 1);
        in_instr = 16'h2020;
        tick();
        in_valid = 1'b0;
        check("il_next_legal", out_illegal, 0);
        check("il_hazard", out_raw_hazard, 1);
        tick();
        check("il_count", dec_count, 8);

        // Back-pressure: three instructions against a stalled sink
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4000;
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_opcode", out_opcode, 4);
        check("bp_ready1", in_ready, 1);
        in_instr = 16'h5000;
        tick();
        check("bp_stable1", out_opcode, 4);
        check("bp_ready2", in_ready, 0);
        in_instr = 16'h6000;
        tick();
        check("bp_stable2", out_opcode, 4);
        check("bp_ready3", in_ready, 0);
        check("bp_count_hold", dec_count, 8);
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", out_valid, 1);
        check("bp_b_opcode", out_opcode, 5);
        check("bp_ready4", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_c_valid", out_valid, 1);
        check("bp_c_opcode", out_opcode, 6);
        tick();
        check("bp_empty", out_valid, 0);
        check("bp_count", dec_count, 11);

        // Flush with both entries full and a pending input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h7000;
        tick();
        in_instr = 16'h8000;
        tick();
        check("fl_full", in_ready, 0);
        in_instr = 16'h9000;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_count", dec_count, 11);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_nothing", out_valid, 0);
        check("fl_count2", dec_count, 11);

        // Reset mid-stream
        in_instr = 16'h3A5C;
        in_valid = 1'b1;
        tick();
        check("mr_valid_before", out_valid, 1);
        reset = 1'b0;
        tick();
        check("mr_valid", out_valid, 0);
        check("mr_ready", in_ready, 1);
        check("mr_opcode", out_opcode, 0);
        check("mr_rd", out_rd, 0);
        check("mr_imm_ext", out_imm_ext, 0);
        check("mr_count", dec_count, 0);

        // Tracker cleared by reset (stale last_rd was 5), then 5 back-to-back transfers
        reset    = 1'b1;
        in_instr = 16'h00A0;
        tick();
        check("wr_hazard", out_raw_hazard, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        check("wr_empty", out_valid, 0);
        check("wr_count", dec_count, 5);
        check("wr_wrap", w_dec_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
